// File: rtl/axi_wr_slave_pkg.sv
// axi_wr_slave_pkg: shared types and constants for the AXI3 write-channel
// slave controller and its burst address generator.
//   state_t       : controller FSM states
//   BURST_*       : AXI burst type encodings
//   RESP_*        : AXI write response encodings
package axi_wr_slave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for an AXI burst.
//   addr      in  : current beat address
//   size      in  : AxSIZE (bytes per beat = 1<<size)
//   len       in  : AxLEN (beats - 1), sets the WRAP block size
//   burst     in  : AxBURST (FIXED/INCR/WRAP; reserved holds the address)
//   next_addr out : address of the following beat
module axi_burst_addr_gen
   import axi_wr_slave_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        size,
   input  logic [LEN_W-1:0]  len,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr
);

   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] blk_mask;

   always_comb begin
      step     = ADDR_W'(1) << size;
      // INCR aligns first, so an unaligned start lands on the next size boundary
      incr     = (addr & ~(step - ADDR_W'(1))) + step;
      // WRAP block is (len+1) beats; keep the base, wrap the offset
      blk_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      case (burst)
         BURST_INCR: next_addr = incr;
         BURST_WRAP: next_addr = (addr & ~blk_mask) | (incr & blk_mask);
         default:    next_addr = addr;
      endcase
   end

endmodule

// File: rtl/axi_wr_slave_ctrl.sv
// axi_wr_slave_ctrl: AXI3 write-channel slave, one burst at a time, turning
// each accepted W beat into a registered SRAM word write and issuing one B.
//   aclk/areset            : clock, synchronous active-high reset
//   aw* / awvalid/awready  : write address channel (lock/cache/prot ignored)
//   w*  / wvalid/wready    : write data channel
//   bid/bresp/bvalid/bready: write response channel
//   mem_we/addr/wdata/wstrb: registered SRAM write port
// Optional: define AXI_WR_SLAVE_WID_CHECK_EN to compare each beat's wid with
// the burst id; a mismatch flags SLVERR and drops that beat's write.
module axi_wr_slave_ctrl
   import axi_wr_slave_pkg::*;
#(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4,
   parameter int MEM_AW = 10
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ID_W-1:0]       awid,
   input  logic [ADDR_W-1:0]     awaddr,
   input  logic [LEN_W-1:0]      awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic [1:0]            awlock,
   input  logic [3:0]            awcache,
   input  logic [2:0]            awprot,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [ID_W-1:0]       wid,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [ID_W-1:0]       bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   output logic                  mem_we,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb
);

   localparam int B     = $clog2(DATA_W/8);
   localparam int CNT_W = LEN_W + 1;

   state_t            state;
   logic [ID_W-1:0]   id_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [2:0]        size_q;
   logic [1:0]        burst_q;
   logic [CNT_W-1:0]  beat_q;
   logic              err_q;
   logic              aw_err_q;   // error known at AW time: suppresses all writes
   logic [ADDR_W-1:0] next_addr;

   logic              aw_hs, w_hs;
   logic [LEN_W:0]    len_ext;
   logic              wrap_len_ok, aw_bad;
   logic              at_len, in_range, last_err, wid_bad, beat_err, wr_ok;

   wire unused_aw = ^{awlock, awcache, awprot};

   assign awready = (state == ST_IDLE) && !areset;
   assign wready  = (state == ST_DATA) && !areset;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;

   // WRAP needs 2/4/8/16 beats and a size-aligned start
   assign len_ext     = {1'b0, awlen};
   assign wrap_len_ok = (awlen != '0) && ((len_ext & (len_ext + 1'b1)) == '0) &&
                        (len_ext < (LEN_W+1)'(16));
   assign aw_bad = (awburst == 2'b11) || (awsize > 3'(B)) ||
                   ((awburst == BURST_WRAP) &&
                    (!wrap_len_ok || ((awaddr & ((ADDR_W'(1) << awsize) - ADDR_W'(1))) != '0)));

`ifdef AXI_WR_SLAVE_WID_CHECK_EN
   assign wid_bad = (wid != id_q);
`else
   wire unused_wid = ^wid;
   assign wid_bad = 1'b0;
`endif

   assign at_len   = (beat_q == {1'b0, len_q});
   assign in_range = (beat_q <= {1'b0, len_q});
   assign last_err = wlast ? !at_len : at_len;
   assign beat_err = last_err || wid_bad;
   assign wr_ok    = !aw_err_q && in_range && !wid_bad;

   axi_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
      .addr      (addr_q),
      .size      (size_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= ST_IDLE;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         aw_err_q  <= 1'b0;
         bvalid    <= 1'b0;
         bid       <= '0;
         bresp     <= RESP_OKAY;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            ST_IDLE: if (aw_hs) begin
               id_q     <= awid;
               addr_q   <= awaddr;
               len_q    <= awlen;
               size_q   <= awsize;
               burst_q  <= awburst;
               beat_q   <= '0;
               err_q    <= aw_bad;
               aw_err_q <= aw_bad;
               state    <= ST_DATA;
            end
            ST_DATA: if (w_hs) begin
               mem_we    <= wr_ok;
               mem_addr  <= addr_q[MEM_AW+B-1:B];
               mem_wdata <= wdata;
               mem_wstrb <= wstrb;
               addr_q    <= next_addr;
               // saturate so overlong bursts never wrap back into range
               if (beat_q != '1) beat_q <= beat_q + 1'b1;
               err_q     <= err_q || beat_err;
               if (wlast) begin
                  state  <= ST_RESP;
                  bvalid <= 1'b1;
                  bid    <= id_q;
                  bresp  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
               end
            end
            ST_RESP: if (bready) begin
               bvalid <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_slave_ctrl.sv
module tb_axi_wr_slave_ctrl;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [3:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [3:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic [1:0]  awlock = '0;
   logic [3:0]  awcache = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [3:0]  wid = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   typedef struct {
      logic [9:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
   } wr_t;

   wr_t exp_q[$];
   int  wr_cyc[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  wr_cnt = 0;
   int  last_aw_cyc = 0;

   axi_wr_slave_ctrl dut (
      .aclk(aclk), .areset(areset),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   // scoreboard: every SRAM write must match the oldest expected write
   always @(negedge aclk) begin
      if (mem_we) begin
         wr_t e;
         wr_cnt++;
         wr_cyc.push_back(cyc);
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write got a=%h d=%h s=%h, none expected", mem_addr, mem_wdata, mem_wstrb);
         end else begin
            e = exp_q.pop_front();
            if (mem_addr !== e.a || mem_wdata !== e.d || mem_wstrb !== e.s) begin
               fails++;
               $display("FAIL write got a=%h d=%h s=%h want a=%h d=%h s=%h",
                        mem_addr, mem_wdata, mem_wstrb, e.a, e.d, e.s);
            end
         end
      end
   end

   task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      while (!awready && n < 20) begin @(posedge aclk); #1; n++; end
      tests++;
      if (awready !== 1'b1) begin fails++; $display("FAIL aw_wait awready=%b want 1", awready); end
      @(posedge aclk); #1;
      last_aw_cyc = cyc;
      awvalid = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic last,
                       input logic [3:0] id, input logic exp_wr, input logic [9:0] exp_a);
      int n = 0;
      wdata = d; wstrb = s; wlast = last; wid = id; wvalid = 1'b1;
      while (!wready && n < 20) begin @(posedge aclk); #1; n++; end
      tests++;
      if (wready !== 1'b1) begin fails++; $display("FAIL w_wait wready=%b want 1", wready); end
      if (exp_wr) exp_q.push_back('{a: exp_a, d: d, s: s});
      @(posedge aclk); #1;
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic wait_b(input logic [3:0] id, input logic [1:0] resp);
      int n = 0;
      bready = 1'b1;
      while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
      tests++;
      if (bvalid !== 1'b1 || bid !== id || bresp !== resp) begin
         fails++;
         $display("FAIL b_resp got v=%b id=%h r=%h want v=1 id=%h r=%h", bvalid, bid, bresp, id, resp);
      end
      @(posedge aclk); #1;
      bready = 1'b0;
      tests++;
      if (awready !== 1'b1 || bvalid !== 1'b0) begin
         fails++;
         $display("FAIL back_to_idle got awready=%b bvalid=%b want 1 0", awready, bvalid);
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL missing_writes got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge aclk);
      #1;
      tests++;
      if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 4'h0 || bresp !== 2'b00 ||
          mem_we !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
         fails++;
         $display("FAIL reset_state awr=%b wr=%b bv=%b bid=%h br=%h we=%b a=%h d=%h s=%h want all 0",
                  awready, wready, bvalid, bid, bresp, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      areset = 1'b0;
      @(posedge aclk); #1;
      tests++;
      if (awready !== 1'b1) begin fails++; $display("FAIL reset_release awready=%b want 1", awready); end
   endtask

   task automatic test_incr();
      wr_cyc.delete();
      do_aw(4'h5, 32'h100, 4'd3, 3'd2, 2'd1);
      for (int i = 0; i < 4; i++) beat(32'hA0 + i, 4'hF, i == 3, 4'h5, 1'b1, 10'(10'h40 + i));
      wait_b(4'h5, 2'b00);
      tests++;
      if (wr_cyc.size() != 4) begin
         fails++;
         $display("FAIL incr_count got %0d want 4", wr_cyc.size());
      end else if (wr_cyc[3] - wr_cyc[0] != 3) begin
         fails++;
         $display("FAIL incr_consecutive got span %0d want 3", wr_cyc[3] - wr_cyc[0]);
      end
   endtask

   task automatic test_wrap();
      logic [9:0] exp_a[4] = '{10'h6, 10'h7, 10'h4, 10'h5};
      do_aw(4'h2, 32'h18, 4'd3, 3'd2, 2'd2);
      for (int i = 0; i < 4; i++) beat(32'hB0 + i, 4'hF, i == 3, 4'h2, 1'b1, exp_a[i]);
      wait_b(4'h2, 2'b00);
   endtask

   task automatic test_fixed();
      logic [31:0] d[3] = '{32'h11, 32'h22, 32'h33};
      int base = wr_cnt;
      do_aw(4'h3, 32'h20, 4'd2, 3'd2, 2'd0);
      for (int i = 0; i < 3; i++) beat(d[i], 4'h3, i == 2, 4'h3, 1'b1, 10'h8);
      wait_b(4'h3, 2'b00);
      tests++;
      if (wr_cnt - base != 3) begin fails++; $display("FAIL fixed_count got %0d want 3", wr_cnt - base); end
   endtask

   task automatic test_early_wlast();
      int base = wr_cnt;
      do_aw(4'h4, 32'h0, 4'd3, 3'd2, 2'd1);
      beat(32'hC0, 4'hF, 1'b0, 4'h4, 1'b1, 10'h0);
      beat(32'hC1, 4'hF, 1'b1, 4'h4, 1'b1, 10'h1);
      wait_b(4'h4, 2'b10);
      tests++;
      if (wr_cnt - base != 2) begin fails++; $display("FAIL early_wlast_count got %0d want 2", wr_cnt - base); end
   endtask

   // reserved burst, oversize beat, misaligned wrap: all SLVERR with no writes
   task automatic test_aw_errors();
      logic [31:0] addr[3]  = '{32'h40, 32'h40, 32'h42};
      logic [2:0]  size[3]  = '{3'd2, 3'd3, 3'd2};
      logic [1:0]  burst[3] = '{2'b11, 2'b01, 2'b10};
      for (int c = 0; c < 3; c++) begin
         int base = wr_cnt;
         do_aw(4'h6, addr[c], 4'd1, size[c], burst[c]);
         beat(32'hDEAD0000 + c, 4'hF, 1'b0, 4'h6, 1'b0, 10'h0);
         beat(32'hDEAD0100 + c, 4'hF, 1'b1, 4'h6, 1'b0, 10'h0);
         wait_b(4'h6, 2'b10);
         tests++;
         if (wr_cnt != base) begin fails++; $display("FAIL aw_err_%0d writes got %0d want 0", c, wr_cnt - base); end
      end
   endtask

`ifdef AXI_WR_SLAVE_WID_CHECK_EN
   task automatic test_wid();
      int base = wr_cnt;
      do_aw(4'h7, 32'h0, 4'd1, 3'd2, 2'd1);
      beat(32'hF0, 4'hF, 1'b0, 4'h8, 1'b0, 10'h0);
      beat(32'hF1, 4'hF, 1'b1, 4'h7, 1'b1, 10'h1);
      wait_b(4'h7, 2'b10);
      tests++;
      if (wr_cnt - base != 1) begin fails++; $display("FAIL wid_count got %0d want 1", wr_cnt - base); end
   endtask
`endif

   task automatic test_back_to_back();
      int first;
      do_aw(4'h1, 32'h200, 4'd1, 3'd2, 2'd1);
      first = last_aw_cyc;
      beat(32'h51, 4'h1, 1'b0, 4'h1, 1'b1, 10'h80);
      beat(32'h52, 4'h2, 1'b1, 4'h1, 1'b1, 10'h81);
      wait_b(4'h1, 2'b00);
      do_aw(4'hE, 32'h300, 4'd0, 3'd2, 2'd1);
      tests++;
      if (last_aw_cyc - first != 4) begin
         fails++;
         $display("FAIL occupancy got %0d cycles want 4", last_aw_cyc - first);
      end
      beat(32'h53, 4'hF, 1'b1, 4'hE, 1'b1, 10'hC0);
      wait_b(4'hE, 2'b00);
   endtask

   task automatic test_bready_hold_reset();
      do_aw(4'h9, 32'h0, 4'd0, 3'd2, 2'd1);
      beat(32'hD0, 4'hF, 1'b1, 4'h9, 1'b1, 10'h0);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (bvalid !== 1'b1 || bid !== 4'h9 || bresp !== 2'b00) begin
            fails++;
            $display("FAIL b_hold_%0d got v=%b id=%h r=%h want 1 9 0", i, bvalid, bid, bresp);
         end
         @(posedge aclk); #1;
      end
      areset = 1'b1;
      @(posedge aclk); #1;
      tests++;
      if (awready !== 1'b0 || bvalid !== 1'b0) begin
         fails++;
         $display("FAIL in_reset got awready=%b bvalid=%b want 0 0", awready, bvalid);
      end
      areset = 1'b0;
      @(posedge aclk); #1;
      tests++;
      if (awready !== 1'b1 || bvalid !== 1'b0 || bid !== 4'h0 || bresp !== 2'b00 || mem_we !== 1'b0 ||
          mem_addr !== 10'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
         fails++;
         $display("FAIL after_reset awr=%b bv=%b bid=%h br=%h we=%b a=%h d=%h s=%h want 1 and rest 0",
                  awready, bvalid, bid, bresp, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      // mid-burst reset: beat 1 is offered while reset is high and must never land
      do_aw(4'hA, 32'h0, 4'd3, 3'd2, 2'd1);
      beat(32'hE0, 4'hF, 1'b0, 4'hA, 1'b1, 10'h0);
      wdata = 32'hE1; wvalid = 1'b1; areset = 1'b1;
      @(posedge aclk); #1;
      tests++;
      if (mem_we !== 1'b0 || bvalid !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset got we=%b bvalid=%b want 0 0", mem_we, bvalid);
      end
      areset = 1'b0; wvalid = 1'b0;
      repeat (2) begin
         @(posedge aclk); #1;
         tests++;
         if (awready !== 1'b1 || bvalid !== 1'b0 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL abandoned_burst got awready=%b bvalid=%b we=%b want 1 0 0", awready, bvalid, mem_we);
         end
      end
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL reset_pending got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_fixed();
      test_early_wlast();
      test_aw_errors();
`ifdef AXI_WR_SLAVE_WID_CHECK_EN
      test_wid();
`endif
      test_back_to_back();
      test_bready_hold_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
